// File: rtl/icache_data_sram_ctrl.sv
// rtl/icache_data_sram_ctrl.sv - I-cache data SRAM port arbiter: fetch reads vs two-beat refill writes.
// Optional ICACHE_SRAM_CTRL_STATS_EN adds stat_reads/stat_fills/stat_fetch_stalls counters.
module icache_data_sram_ctrl #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_req_valid,
    output logic                    fetch_req_ready,
    input  logic [ADDR_WIDTH-1:0]   fetch_req_idx,
    output logic                    fetch_resp_valid,
    output logic [DATA_WIDTH-1:0]   fetch_resp_data,
    input  logic                    fill_valid,
    output logic                    fill_ready,
    input  logic [ADDR_WIDTH-1:0]   fill_idx,
    input  logic [DATA_WIDTH/2-1:0] fill_data,
    output logic                    fill_line_done,
    output logic                    busy,
    output logic                    sram_csb,
    output logic                    sram_web,
    output logic [1:0]              sram_wmask,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_din,
    input  logic [DATA_WIDTH-1:0]   sram_dout
`ifdef ICACHE_SRAM_CTRL_STATS_EN
    ,
    output logic [15:0]             stat_reads,
    output logic [15:0]             stat_fills,
    output logic [15:0]             stat_fetch_stalls
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fill_idx_q, fill_idx_d;
    logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;
    logic                    rd_pend_q;
    logic                    resp_valid_q;
    logic [DATA_WIDTH-1:0]   resp_data_q;

    logic hazard;
    logic fetch_ok;
    logic fetch_gnt;
    logic fill_gnt;

    always_comb begin
        state_d        = state_q;
        fill_idx_d     = fill_idx_q;
        starve_cnt_d   = starve_cnt_q;
        fetch_gnt      = 1'b0;
        fill_gnt       = 1'b0;
        fill_line_done = 1'b0;
        sram_csb       = 1'b1;
        sram_web       = 1'b1;
        sram_wmask     = 2'b00;
        sram_addr      = '0;
        sram_din       = '0;

        // A fetch to the half-written line must wait, otherwise it reads a torn line.
        hazard   = (state_q == S_FILL) && (fetch_req_idx == fill_idx_q);
        fetch_ok = fetch_req_valid && !hazard;

        if (!rst) begin
            if (fetch_ok && (!fill_valid || starve_cnt_q == STARVE_MAX)) begin
                fetch_gnt = 1'b1;
            end else if (fill_valid) begin
                fill_gnt = 1'b1;
            end
        end

        if (fetch_gnt) begin
            sram_csb  = 1'b0;
            sram_addr = fetch_req_idx;
        end else if (fill_gnt) begin
            sram_csb = 1'b0;
            sram_web = 1'b0;
            sram_din = {fill_data, fill_data};
            if (state_q == S_IDLE) begin
                sram_wmask = 2'b01;
                sram_addr  = fill_idx;
                fill_idx_d = fill_idx;
                state_d    = S_FILL;
            end else begin
                sram_wmask     = 2'b10;
                sram_addr      = fill_idx_q;
                fill_line_done = 1'b1;
                state_d        = S_IDLE;
            end
        end

        if (fetch_gnt || !fetch_req_valid) begin
            starve_cnt_d = '0;
        end else if (fill_gnt && fetch_ok && starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    assign fetch_req_ready  = fetch_gnt;
    assign fill_ready       = fill_gnt;
    assign fetch_resp_valid = resp_valid_q;
    assign fetch_resp_data  = resp_data_q;
    assign busy             = (state_q == S_FILL) || rd_pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fill_idx_q   <= '0;
            starve_cnt_q <= '0;
            rd_pend_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            fill_idx_q   <= fill_idx_d;
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= fetch_gnt;
            resp_valid_q <= rd_pend_q;
            // sram_dout is only meaningful the cycle after a read grant.
            if (rd_pend_q) begin
                resp_data_q <= sram_dout;
            end
        end
    end

`ifdef ICACHE_SRAM_CTRL_STATS_EN
    logic [15:0] stat_reads_q, stat_fills_q, stat_stalls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_reads_q  <= '0;
            stat_fills_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (fetch_gnt) begin
                stat_reads_q <= stat_reads_q + 16'd1;
            end
            if (fill_line_done) begin
                stat_fills_q <= stat_fills_q + 16'd1;
            end
            if (fetch_req_valid && !fetch_req_ready) begin
                stat_stalls_q <= stat_stalls_q + 16'd1;
            end
        end
    end

    assign stat_reads        = stat_reads_q;
    assign stat_fills        = stat_fills_q;
    assign stat_fetch_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_icache_data_sram_ctrl.sv
// tb/tb_icache_data_sram_ctrl.sv - randomized bench for icache_data_sram_ctrl with a line-level reference model.
module tb_icache_data_sram_ctrl;

    localparam int AW = 6;
    localparam int DW = 128;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req_valid;
    logic          fetch_req_ready;
    logic [AW-1:0] fetch_req_idx;
    logic          fetch_resp_valid;
    logic [DW-1:0] fetch_resp_data;
    logic          fill_valid;
    logic          fill_ready;
    logic [AW-1:0] fill_idx;
    logic [63:0]   fill_data;
    logic          fill_line_done;
    logic          busy;
    logic          sram_csb;
    logic          sram_web;
    logic [1:0]    sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;
`ifdef ICACHE_SRAM_CTRL_STATS_EN
    logic [15:0]   stat_reads, stat_fills, stat_fetch_stalls;
`endif

    always #5 clk = ~clk;

    icache_data_sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
        .fetch_req_idx(fetch_req_idx), .fetch_resp_valid(fetch_resp_valid),
        .fetch_resp_data(fetch_resp_data), .fill_valid(fill_valid), .fill_ready(fill_ready),
        .fill_idx(fill_idx), .fill_data(fill_data), .fill_line_done(fill_line_done),
        .busy(busy), .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
`ifdef ICACHE_SRAM_CTRL_STATS_EN
        , .stat_reads(stat_reads), .stat_fills(stat_fills), .stat_fetch_stalls(stat_fetch_stalls)
`endif
    );

    function automatic logic [DW-1:0] init_pattern(input int i);
        return {4{32'hC0DE_0000 | 32'(i)}};
    endfunction

    // SRAM macro model: pins latched at posedge, read data out after posedge, write at negedge.
    logic [DW-1:0] mem [64];
    bit            mem_init_done;
    bit            w_pend;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_din;
    logic [1:0]    w_mask;

    always @(posedge clk) begin
        w_pend <= !sram_csb && !sram_web;
        w_addr <= sram_addr;
        w_din  <= sram_din;
        w_mask <= sram_wmask;
        if (!sram_csb && sram_web) sram_dout <= mem[sram_addr];
    end

    always @(negedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_pattern(i);
            mem_init_done <= 1'b1;
        end else if (w_pend) begin
            if (w_mask[0]) mem[w_addr][63:0]   <= w_din[63:0];
            if (w_mask[1]) mem[w_addr][127:64] <= w_din[127:64];
        end
    end

    // Reference model: contents per line, fill phase, starvation count, response pipe.
    logic [DW-1:0] ref_mem [64];
    bit            m_in_fill;
    logic [AW-1:0] m_line;
    int            m_starve;
    bit            m_v1, m_v2;
    logic [DW-1:0] m_d1, m_rdata;
    int            m_reads, m_fills, m_stalls;
    int            obs_fetch_gnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit fv, input logic [AW-1:0] fi,
                        input bit lv, input logic [AW-1:0] li, input logic [63:0] ld);
        bit want, e_fg, e_lg, e_done;
        logic [1:0]    e_mask;
        logic [AW-1:0] e_addr;
        rst = r; fetch_req_valid = fv; fetch_req_idx = fi;
        fill_valid = lv; fill_idx = li; fill_data = ld;
        #1;
        want = fv && !(m_in_fill && fi == m_line);
        e_fg = !r && want && (!lv || m_starve == SL);
        e_lg = !r && lv && !e_fg;
        e_done = e_lg && m_in_fill;
        e_mask = !e_lg ? 2'b00 : (m_in_fill ? 2'b10 : 2'b01);
        e_addr = e_fg ? fi : (e_lg ? (m_in_fill ? m_line : li) : '0);
        check_eq("ready", DW'({fetch_req_ready, fill_ready}), DW'({e_fg, e_lg}));
        check_eq("sram_ctl", DW'({sram_csb, sram_web, sram_wmask}),
                 DW'({!(e_fg || e_lg), !e_lg, e_mask}));
        check_eq("sram_addr", DW'(sram_addr), DW'(e_addr));
        check_eq("sram_din", sram_din, e_lg ? {ld, ld} : '0);
        check_eq("line_done", DW'(fill_line_done), DW'(e_done));
        check_eq("busy", DW'(busy), DW'(m_in_fill || m_v1));
        check_eq("resp_valid", DW'(fetch_resp_valid), DW'(m_v2));
        check_eq("resp_data", fetch_resp_data, m_rdata);
`ifdef ICACHE_SRAM_CTRL_STATS_EN
        check_eq("stat_reads", DW'(stat_reads), DW'(m_reads[15:0]));
        check_eq("stat_fills", DW'(stat_fills), DW'(m_fills[15:0]));
        check_eq("stat_stalls", DW'(stat_fetch_stalls), DW'(m_stalls[15:0]));
`endif
        if (fetch_req_ready) obs_fetch_gnt++;
        @(posedge clk);
        if (r) begin
            m_in_fill = 0; m_line = '0; m_starve = 0;
            m_v1 = 0; m_v2 = 0; m_rdata = '0;
            m_reads = 0; m_fills = 0; m_stalls = 0;
        end else begin
            if (m_v1) m_rdata = m_d1;
            m_v2 = m_v1;
            m_v1 = e_fg;
            if (e_fg) m_d1 = ref_mem[fi];
            m_reads  += int'(e_fg);
            m_fills  += int'(e_done);
            m_stalls += int'(fv && !e_fg);
            if (e_fg || !fv) m_starve = 0;
            else if (e_lg && want && m_starve < SL) m_starve++;
            if (e_lg) begin
                if (!m_in_fill) begin
                    m_line = li;
                    ref_mem[li][63:0] = ld;
                    m_in_fill = 1;
                end else begin
                    ref_mem[m_line][127:64] = ld;
                    m_in_fill = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_pattern(i);
        m_line = '0; m_d1 = '0; m_rdata = '0;
        rst = 1; fetch_req_valid = 0; fetch_req_idx = '0;
        fill_valid = 0; fill_idx = '0; fill_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0);

        // Fill line 5 then read it back.
        step(0, 0, 0, 1, 5, 64'hA);
        step(0, 0, 0, 1, 9, 64'hB);
        step(0, 1, 5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_eq("t1_line", fetch_resp_data, {64'hB, 64'hA});
        step(0, 0, 0, 0, 0, 0);

        // Back-to-back reads.
        for (int i = 0; i < 3; i++) step(0, 1, AW'(i), 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);

        // Both requesters saturated: four fills then one fetch.
        step(1, 0, 0, 0, 0, 0);
        obs_fetch_gnt = 0;
        for (int i = 0; i < 10; i++) step(0, 1, 30, 1, 20, {$urandom, $urandom});
        check_eq("starve_pattern", DW'(obs_fetch_gnt), DW'(2));
`ifdef ICACHE_SRAM_CTRL_STATS_EN
        check_eq("t6_fills", DW'(stat_fills), DW'(4));
        check_eq("t6_reads", DW'(stat_reads), DW'(2));
        check_eq("t6_stalls", DW'(stat_fetch_stalls), DW'(8));
`endif
        repeat (2) step(0, 0, 0, 0, 0, 0);

        // Hazard on the line being filled.
        step(0, 0, 0, 1, 7, 64'h7777);
        step(0, 1, 7, 0, 0, 0);
        step(0, 1, 8, 0, 0, 0);
        step(0, 1, 7, 1, 0, 64'h7778);
        step(0, 1, 7, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_eq("t4_line", fetch_resp_data, {64'h7778, 64'h7777});
        step(0, 0, 0, 0, 0, 0);

        // Reset mid-fill with a read in flight.
        step(0, 0, 0, 1, 3, 64'h3333);
        step(0, 1, 10, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 9, 64'h9999);
        step(0, 0, 0, 1, 0, 64'h999A);

        // Random traffic on a few lines to provoke hazards and starvation.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, AW'($urandom_range(0, 3)),
                 $urandom_range(0, 2) != 0, AW'($urandom_range(0, 3)), {$urandom, $urandom});
        end
        repeat (3) step(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
